// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI burst/response codes and write FSM state encoding
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO used as the AW command queue
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Storage array: written on accepted pushes only, never reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; simultaneous push and pop keep the count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_wr_sram.sv
// rtl/axi_wr_sram.sv - AXI write slave converting bursts into registered SRAM word writes
module axi_wr_sram
  import axi_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int AW_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   AWID,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic [7:0]            AWLEN,
  input  logic [2:0]            AWSIZE,
  input  logic [1:0]            AWBURST,
  input  logic [3:0]            AWREGION,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic [STRB_WIDTH-1:0] WSTRB,
  input  logic                  WLAST,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [ID_WIDTH-1:0]   BID,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-4:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [STRB_WIDTH-1:0] mem_be
);

  localparam int QW       = ID_WIDTH + ADDR_WIDTH + 8 + 3 + 2;
  localparam int MAX_SIZE = $clog2(STRB_WIDTH);

  state_t                state;
  logic [QW-1:0]         q_din;
  logic [QW-1:0]         q_dout;
  logic                  q_full;
  logic                  q_empty;
  logic                  push;
  logic                  pop;

  logic [ID_WIDTH-1:0]   h_id;
  logic [ADDR_WIDTH-1:0] h_addr;
  logic [7:0]            h_len;
  logic [2:0]            h_size;
  logic [1:0]            h_burst;
  logic                  h_err;

  logic [ID_WIDTH-1:0]   b_id;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [7:0]            b_len;
  logic [2:0]            b_size;
  logic [1:0]            b_burst;
  logic                  b_err;
  logic [7:0]            beat_cnt;
  logic                  last_beat;

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] next_addr;

  logic                  unused_region;
  assign unused_region = ^AWREGION;

  assign q_din   = {AWID, AWADDR, AWLEN, AWSIZE, AWBURST};
  assign AWREADY = !q_full;
  assign push    = AWVALID && !q_full;
  assign pop     = (state == ST_IDLE) && !q_empty;

  sync_fifo #(
    .WIDTH (QW),
    .DEPTH (AW_DEPTH)
  ) u_aw_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (q_din),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty)
  );

  assign {h_id, h_addr, h_len, h_size, h_burst} = q_dout;

  // Classify the queue head: reserved burst, oversize beat or illegal wrap length
  always_comb begin
    h_err = 1'b0;
    if (h_burst == 2'b11) h_err = 1'b1;
    if (h_size > 3'(MAX_SIZE)) h_err = 1'b1;
    if (h_burst == BURST_WRAP &&
        !(h_len == 8'd1 || h_len == 8'd3 || h_len == 8'd7 || h_len == 8'd15))
      h_err = 1'b1;
  end

  assign last_beat = (beat_cnt == b_len);

  // Next beat address; WRAP stays inside the (len+1)<<size aligned window
  always_comb begin
    step      = ADDR_WIDTH'(1) << b_size;
    wrap_mask = ((ADDR_WIDTH'(b_len) + ADDR_WIDTH'(1)) << b_size) - ADDR_WIDTH'(1);
    next_addr = b_addr;
    case (b_burst)
      BURST_FIXED: next_addr = b_addr;
      BURST_INCR:  next_addr = b_addr + step;
      BURST_WRAP:  next_addr = (b_addr & ~wrap_mask) | ((b_addr + step) & wrap_mask);
      default:     next_addr = b_addr;
    endcase
  end

  // Burst FSM with registered W/B handshake outputs and SRAM write port
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      WREADY    <= 1'b0;
      BVALID    <= 1'b0;
      BID       <= '0;
      BRESP     <= RESP_OKAY;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      b_id      <= '0;
      b_addr    <= '0;
      b_len     <= '0;
      b_size    <= '0;
      b_burst   <= '0;
      b_err     <= 1'b0;
      beat_cnt  <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!q_empty) begin
            b_id     <= h_id;
            b_addr   <= h_addr;
            b_len    <= h_len;
            b_size   <= h_size;
            b_burst  <= h_burst;
            b_err    <= h_err;
            beat_cnt <= '0;
            WREADY   <= 1'b1;
            state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (WVALID && WREADY) begin
            mem_we    <= !b_err;
            mem_addr  <= b_addr[ADDR_WIDTH-1:3];
            mem_wdata <= WDATA;
            mem_be    <= WSTRB;
            if (WLAST || last_beat) begin
              // Early WLAST, missing WLAST or an error burst all report SLVERR
              WREADY <= 1'b0;
              BVALID <= 1'b1;
              BID    <= b_id;
              BRESP  <= (b_err || !last_beat || !WLAST) ? RESP_SLVERR : RESP_OKAY;
              state  <= ST_RESP;
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
              b_addr   <= next_addr;
            end
          end
        end
        ST_RESP: begin
          if (BREADY) begin
            BVALID <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi_wr_sram.md
AXI_WR_SRAM -- requirements
Module: axi_wr_sram

Interface
REQ-001 Parameters (name, default, meaning):
- ID_WIDTH, 4, AXI ID width
- ADDR_WIDTH, 10, byte address width
- DATA_WIDTH, 64, data width
- STRB_WIDTH, DATA_WIDTH/8, strobe width
- AW_DEPTH, 4, AW queue depth (power of 2)
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 Ports (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- AWID  in  ID_WIDTH  write ID
- AWADDR  in  ADDR_WIDTH  byte address
- AWLEN  in  8  beats-1
- AWSIZE  in  3  log2 bytes/beat
- AWBURST  in  2  burst type
- AWREGION  in  4  ignored
- AWVALID  in  1  AW valid
- AWREADY  out  1  AW ready
- WDATA  in  DATA_WIDTH  write data
- WSTRB  in  STRB_WIDTH  byte strobes
- WLAST  in  1  last beat
- WVALID  in  1  W valid
- WREADY  out  1  W ready
- BID  out  ID_WIDTH  response ID
- BRESP  out  2  response code
- BVALID  out  1  B valid
- BREADY  in  1  B ready
- mem_we  out  1  SRAM write enable
- mem_addr  out  ADDR_WIDTH-3  SRAM word address
- mem_wdata  out  DATA_WIDTH  SRAM write data
- mem_be  out  STRB_WIDTH  SRAM byte enables

Function
REQ-004 AW channel: handshake pushes {AWID, AWADDR, AWLEN, AWSIZE, AWBURST} into the AW queue; AWREADY = queue not full; AWREGION is ignored.
REQ-005 FSM states IDLE, DATA, RESP; IDLE with queue non-empty pops the head, loads the burst registers, clears the beat count and goes to DATA in the next cycle.
REQ-006 An AW accepted in cycle N into an empty queue with the FSM in IDLE: pop in N+1, WREADY=1 from N+2.
REQ-007 WREADY=1 only in DATA; each W handshake increments the beat count; mem_we, mem_addr=addr[ADDR_WIDTH-1:3], mem_wdata=WDATA and mem_be=WSTRB are registered and valid exactly one cycle after the handshake.
REQ-008 Address update per beat:
- FIXED (00): unchanged
- INCR (01): +(1<<size), modulo 2^ADDR_WIDTH
- WRAP (10): incremented within an aligned window of (len+1)<<size bytes, wrapping to the window base
REQ-009 Error bursts: AWBURST=11, AWSIZE>3, or WRAP with len not in {1,3,7,15} -> SLVERR; beats are still accepted but mem_we stays 0.
REQ-010 WLAST check: WLAST on a non-final beat ends the burst early (-> RESP, SLVERR); WLAST=0 on the final beat (count==len) -> SLVERR; otherwise OKAY (00).
REQ-011 A burst ends on the final beat or on an early WLAST; the FSM moves to RESP next cycle with BVALID=1, BID=burst ID, BRESP latched; outputs hold until BREADY, then IDLE.
REQ-012 AW pushes continue during DATA/RESP; a push and a pop in the same cycle leave the occupancy unchanged; a full queue holds AWREADY=0.
REQ-013 AWLEN=0 is a single-beat burst; AWLEN=255 is 256 beats, and the count does not overflow.

Reset
REQ-014 rst=1 at a clock edge: FSM=IDLE, queue empty, AWREADY=1, WREADY=0, BVALID=0, BID=0, BRESP=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0.
REQ-015 Reset mid-burst abandons the burst without a B response; no mem_we in the cycle after reset.

Structure
REQ-016 Shared package axi_pkg holds BURST_FIXED/INCR/WRAP, RESP_OKAY/SLVERR and the FSM state encoding.
REQ-017 The AW queue is sub-module sync_fifo (parameters WIDTH, DEPTH; signals push, pop, full, empty); all other logic is in axi_wr_sram.

Verification
REQ-018 INCR burst: AWADDR=0x040, LEN=3, SIZE=3, ID=5 -> mem_addr 0x08,0x09,0x0A,0x0B; then BID=5, BRESP=00.
REQ-019 WRAP burst: AWADDR=0x058, LEN=3, SIZE=3 -> mem_addr 0x0B,0x08,0x09,0x0A; BRESP=00.
REQ-020 Early WLAST on beat 1 of LEN=3 -> 2 writes, BRESP=10, FSM back in IDLE after BREADY.
REQ-021 AWBURST=11, LEN=1 -> 2 W beats accepted, mem_we never 1, BRESP=10.
REQ-022 Five back-to-back AWs with W held off -> AWREADY=0 after 4 are queued (head popped, queue full); bursts complete in order with matching BIDs.
REQ-023 rst pulsed during beat 2 of LEN=7 -> BVALID=0, AWREADY=1; a fresh burst completes normally.
